armleocpu_memaccess: RTL and testbench
======================================

# armleocpu_memaccess

Load/store access stage between the execute stage and the data bus. It accepts one memory request at a time and checks alignment and type. It then issues a word-aligned bus transaction with byte strobes, waits for the response, and returns sign/zero-extended load data or a store acknowledgement with error flags. Only one request is ever outstanding.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles spent in WAIT before an access fault is raised; 0 disables the timeout; legal range 0..65535.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request from execute
- req_ready  out  1  block can accept a request
- req_addr  in  32  byte address
- req_write  in  1  1 = store, 0 = load
- req_type  in  3  access type; loads use `LOAD_*` encodings, stores use `STORE_*` encodings from armleocpu_defines.vh
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  32  formatted load data; 0 for stores and errors
- resp_missaligned  out  1  alignment error
- resp_unknowntype  out  1  illegal req_type
- resp_accessfault  out  1  bus error or timeout
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts request
- bus_addr  out  32  {req_addr[31:2], 2'b00}
- bus_write  out  1  store flag
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte strobes; 0 for loads
- bus_rvalid  in  1  bus response valid (read data or write ack)
- bus_rdata  in  32  read data
- bus_rerr  in  1  bus response error

## Operation

- States: IDLE, REQ, WAIT, RESP. Reset enters IDLE.
- Reset values:
  - All outputs 0, including req_ready while rst=1.
  - Internal address, type and data registers cleared; timeout counter cleared.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready the block latches addr, write, type and wdata, then checks the request:
    - Unknown type → RESP with resp_unknowntype=1.
    - Misaligned (word: addr[1:0]!=0; half: addr[0]) → RESP with resp_missaligned=1.
    - Otherwise → REQ.
  - Errored requests never reach the bus.
- REQ:
  - bus_valid=1; bus_addr, bus_write, bus_wdata and bus_wstrb are held stable until bus_ready.
  - bus_valid&&bus_ready → WAIT, with the counter cleared.
- WAIT:
  - The counter increments each cycle.
  - On bus_rvalid → RESP, capturing bus_rdata and bus_rerr.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES without bus_rvalid → RESP with resp_accessfault=1.
  - If bus_rvalid and the timeout occur in the same cycle, bus_rvalid wins.
- RESP:
  - resp_valid=1 for exactly one cycle, then → IDLE.
  - Flags are mutually exclusive.
  - resp_data is 0 whenever any flag is set.
- bus_rvalid outside WAIT is ignored, including a late response after a timeout.
- Load formatting:
  - Shift bus_rdata right by {addr[1:0],3'b0}.
  - Word: as shifted.
  - HALF: sign-extend bit 15. HALF_UNSIGNED: zero-extend.
  - BYTE: sign-extend bit 7. BYTE_UNSIGNED: zero-extend.
- Store generation:
  - Byte: wdata {4{wdata[7:0]}}, wstrb 4'b0001<<addr[1:0].
  - Half: wdata {2{wdata[15:0]}}, wstrb 4'b0011<<addr[1:0].
  - Word: wdata unchanged, wstrb 4'b1111.
- Reset asserted in any state returns to IDLE next edge and drops bus_valid and resp_valid; an in-flight bus response is not waited for.

## Timing

- Accept at edge 0 → bus_valid high from cycle 1.
- bus_ready in cycle 1 → WAIT from cycle 2.
- bus_rvalid in cycle 2 → resp_valid in cycle 3 → req_ready high again in cycle 4. Minimum latency is 3 cycles from accept to response.
- Error-on-check path: resp_valid in cycle 1, req_ready in cycle 2.
- resp_valid has no backpressure; the consumer must take it in the pulse cycle.
- All outputs are registered or decoded from state only; there is no combinational path from req_* or bus_* inputs to any output.

## Configuration

- ARMLEOCPU_MEMACCESS_STORE_EN:
  - Defined: store path compiled in as described above.
  - Undefined: the store generation logic is removed; bus_write=0, bus_wdata=0 and bus_wstrb=0 permanently. Any request with req_write=1 is treated as an unknown type: RESP with resp_unknowntype=1, no bus access.

## Test plan

- LOAD_BYTE at addr 0x1003, bus_rdata 0x80FF_0000 with ready/rvalid immediate → bus_addr 0x1000, resp_data 0xFFFF_FF80 in cycle 3, no flags.
- LOAD_HALF_UNSIGNED at 0x2002, rdata 0xBEEF_1234 → resp_data 0x0000_BEEF. LOAD_WORD at 0x2002 → resp_missaligned=1 in cycle 1, bus_valid never asserted.
- STORE_HALF at 0x3002, wdata 0x0000_ABCD (STORE_EN defined) → bus_wdata 0xABCD_ABCD, bus_wstrb 4'b1100, bus_write=1; write ack → resp_valid with resp_data 0.
- TIMEOUT_CYCLES=4, bus_ready=1 and bus_rvalid held 0 → resp_accessfault=1 after 4 WAIT cycles; a later bus_rvalid is ignored and the next request completes normally.
- bus_ready held 0 for 10 cycles → bus outputs stable throughout. rst pulsed in WAIT → all outputs 0 next cycle and IDLE entered.
- req_type 3'b011 → resp_unknowntype=1. With STORE_EN undefined, any store → resp_unknowntype=1 and no bus activity.

Source files
------------

// File: rtl/armleocpu_memaccess.sv
// Load/store access stage: validates a request, runs one word-aligned bus transaction, formats the response.
// Optional store path: define ARMLEOCPU_MEMACCESS_STORE_EN; when undefined, every store is reported as an unknown type.
module armleocpu_memaccess #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_missaligned,
  output logic        resp_unknowntype,
  output logic        resp_accessfault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rerr
);

  localparam logic [2:0] LOAD_BYTE          = 3'b000;
  localparam logic [2:0] LOAD_HALF          = 3'b001;
  localparam logic [2:0] LOAD_WORD          = 3'b010;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
  localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;
`ifdef ARMLEOCPU_MEMACCESS_STORE_EN
  localparam logic [2:0] STORE_BYTE         = 3'b000;
  localparam logic [2:0] STORE_HALF         = 3'b001;
  localparam logic [2:0] STORE_WORD         = 3'b010;
`endif

  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_addr;
  logic        r_write;
  logic [2:0]  r_type;
  logic [15:0] r_counter;
  logic [31:0] r_resp_data;
  logic        r_resp_missaligned;
  logic        r_resp_unknowntype;
  logic        r_resp_accessfault;

  logic        w_type_ok;
  logic        w_misaligned;
  logic        w_timeout;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [31:0] w_bus_wdata;
  logic [3:0]  w_bus_wstrb;

  always_comb begin
    w_type_ok    = 1'b0;
    w_misaligned = 1'b0;
    if (req_write) begin
`ifdef ARMLEOCPU_MEMACCESS_STORE_EN
      case (req_type)
        STORE_BYTE: w_type_ok = 1'b1;
        STORE_HALF: begin
          w_type_ok    = 1'b1;
          w_misaligned = req_addr[0];
        end
        STORE_WORD: begin
          w_type_ok    = 1'b1;
          w_misaligned = |req_addr[1:0];
        end
        default: w_type_ok = 1'b0;
      endcase
`endif
    end else begin
      case (req_type)
        LOAD_BYTE, LOAD_BYTE_UNSIGNED: w_type_ok = 1'b1;
        LOAD_HALF, LOAD_HALF_UNSIGNED: begin
          w_type_ok    = 1'b1;
          w_misaligned = req_addr[0];
        end
        LOAD_WORD: begin
          w_type_ok    = 1'b1;
          w_misaligned = |req_addr[1:0];
        end
        default: w_type_ok = 1'b0;
      endcase
    end
  end

  assign w_timeout = TIMEOUT_EN && (r_counter == TIMEOUT_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_next = (!w_type_ok || w_misaligned) ? S_RESP : S_REQ;
      S_REQ:  if (bus_ready) w_state_next = S_WAIT;
      S_WAIT: if (bus_rvalid || w_timeout) w_state_next = S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Lane select from the latched address, then extend per access type
  assign w_shifted = bus_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_type)
      LOAD_BYTE:          w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LOAD_BYTE_UNSIGNED: w_load_data = {24'h0, w_shifted[7:0]};
      LOAD_HALF:          w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LOAD_HALF_UNSIGNED: w_load_data = {16'h0, w_shifted[15:0]};
      LOAD_WORD:          w_load_data = w_shifted;
      default:            w_load_data = w_shifted;
    endcase
  end

`ifdef ARMLEOCPU_MEMACCESS_STORE_EN
  logic [31:0] r_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdata <= 32'h0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_wdata <= req_wdata;
    end
  end

  always_comb begin
    w_bus_wdata = 32'h0;
    w_bus_wstrb = 4'h0;
    if (r_write) begin
      case (r_type)
        STORE_BYTE: begin
          w_bus_wdata = {4{r_wdata[7:0]}};
          w_bus_wstrb = 4'b0001 << r_addr[1:0];
        end
        STORE_HALF: begin
          w_bus_wdata = {2{r_wdata[15:0]}};
          w_bus_wstrb = 4'b0011 << r_addr[1:0];
        end
        default: begin
          w_bus_wdata = r_wdata;
          w_bus_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign bus_write = r_write;
`else
  logic w_unused_wdata;
  assign w_unused_wdata = ^req_wdata;
  assign w_bus_wdata    = 32'h0;
  assign w_bus_wstrb    = 4'h0;
  assign bus_write      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_addr             <= 32'h0;
      r_write            <= 1'b0;
      r_type             <= 3'h0;
      r_counter          <= 16'h0;
      r_resp_data        <= 32'h0;
      r_resp_missaligned <= 1'b0;
      r_resp_unknowntype <= 1'b0;
      r_resp_accessfault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr             <= req_addr;
          r_write            <= req_write;
          r_type             <= req_type;
          r_resp_data        <= 32'h0;
          r_resp_unknowntype <= !w_type_ok;
          r_resp_missaligned <= w_type_ok && w_misaligned;
          r_resp_accessfault <= 1'b0;
        end
        S_REQ: if (bus_ready) r_counter <= 16'h0;
        S_WAIT: begin
          r_counter <= r_counter + 16'd1;
          // A response arriving on the timeout cycle takes priority over the fault
          if (bus_rvalid) begin
            r_resp_accessfault <= bus_rerr;
            r_resp_data        <= (bus_rerr || r_write) ? 32'h0 : w_load_data;
          end else if (w_timeout) begin
            r_resp_accessfault <= 1'b1;
            r_resp_data        <= 32'h0;
          end
        end
        S_RESP: begin
          r_resp_data        <= 32'h0;
          r_resp_missaligned <= 1'b0;
          r_resp_unknowntype <= 1'b0;
          r_resp_accessfault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready        = (r_state == S_IDLE) && !rst;
  assign bus_valid        = (r_state == S_REQ);
  assign resp_valid       = (r_state == S_RESP);
  assign bus_addr         = {r_addr[31:2], 2'b00};
  assign bus_wdata        = w_bus_wdata;
  assign bus_wstrb        = w_bus_wstrb;
  assign resp_data        = r_resp_data;
  assign resp_missaligned = r_resp_missaligned;
  assign resp_unknowntype = r_resp_unknowntype;
  assign resp_accessfault = r_resp_accessfault;

endmodule

// File: tb/tb_armleocpu_memaccess.sv
// Randomized and directed bench for armleocpu_memaccess, checked against an arithmetic model of the access rules.
module tb_armleocpu_memaccess;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_write = 1'b0;
  logic [2:0]  req_type = 3'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_missaligned;
  logic        resp_unknowntype;
  logic        resp_accessfault;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_rerr = 1'b0;

  int checks = 0;
  int errors = 0;

  armleocpu_memaccess #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_type(req_type), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_missaligned(resp_missaligned),
    .resp_unknowntype(resp_unknowntype), .resp_accessfault(resp_accessfault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rerr(bus_rerr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request; expectations come from size/lane arithmetic, not from DUT state.
  task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [2:0] typ,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic rerr,
                        input int rdy_dly, input int rv_dly, input string tag);
    int          size;
    int          lane;
    bit          legal;
    bit          exp_mis, exp_unk, exp_af;
    logic [63:0] mask64;
    logic [31:0] mask, v, exp_data, exp_wdata, rep;
    logic [3:0]  exp_wstrb;
    logic [70:0] exp_bus;
    int          c;
    bit          done;

    size = 1 << typ[1:0];
    lane = int'(addr % 4);
    if (wr) begin
`ifdef ARMLEOCPU_MEMACCESS_STORE_EN
      legal = (typ <= 3'd2);
`else
      legal = 1'b0;
`endif
    end else begin
      legal = (typ <= 3'd2) || (typ == 3'd4) || (typ == 3'd5);
    end
    exp_unk = !legal;
    exp_mis = legal && ((addr % size) != 0);
    mask64  = (64'd1 << (8 * size)) - 64'd1;
    mask    = mask64[31:0];
    v       = (rdata >> (8 * lane)) & mask;
    if (!typ[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    exp_af    = (rv_dly >= T) || rerr;
    exp_data  = (exp_af || wr) ? 32'h0 : v;
    rep       = (size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'h1;
    exp_wdata = wr ? (wdata & mask) * rep : 32'h0;
    exp_wstrb = wr ? 4'(((1 << size) - 1) << lane) : 4'h0;
    exp_bus   = {1'b1, wr, addr & 32'hFFFF_FFFC, exp_wdata, exp_wstrb};

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_before got=%b want=1", tag, req_ready);
    end
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_type = typ; req_wdata = wdata;
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom); req_type = 3'($urandom); req_wdata = $urandom;

    if (exp_unk || exp_mis) begin
      checks++;
      if ({resp_valid, resp_unknowntype, resp_missaligned, resp_accessfault, bus_valid} !== {1'b1, exp_unk, exp_mis, 2'b00}
          || resp_data !== 32'h0) begin
        errors++;
        $display("FAIL %s err_resp got v/unk/mis/af/bv=%b%b%b%b%b data=%h want=1%b%b00 data=0",
                 tag, resp_valid, resp_unknowntype, resp_missaligned, resp_accessfault, bus_valid, resp_data, exp_unk, exp_mis);
      end
      tick();
      checks++;
      if ({resp_valid, req_ready, bus_valid} !== 3'b010) begin
        errors++;
        $display("FAIL %s err_after got v/rdy/bv=%b%b%b want=010", tag, resp_valid, req_ready, bus_valid);
      end
      $display("txn %s addr=%h wr=%0d type=%0d -> unk=%0d mis=%0d", tag, addr, wr, typ, exp_unk, exp_mis);
      return;
    end

    for (int i = 0; i <= rdy_dly; i++) begin
      bus_ready = (i == rdy_dly);
      checks++;
      if ({bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb} !== exp_bus || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s bus_req[%0d] got v=%b w=%b a=%h d=%h s=%h rv=%b want v=1 w=%b a=%h d=%h s=%h rv=0",
                 tag, i, bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb, resp_valid,
                 wr, addr & 32'hFFFF_FFFC, exp_wdata, exp_wstrb);
      end
      tick();
    end
    bus_ready = 1'b0;

    c = 0;
    done = 1'b0;
    while (!done) begin
      checks++;
      if ({resp_valid, bus_valid} !== 2'b00) begin
        errors++;
        $display("FAIL %s wait[%0d] got rv/bv=%b%b want=00", tag, c, resp_valid, bus_valid);
      end
      bus_rvalid = (c == rv_dly);
      bus_rdata  = rdata;
      bus_rerr   = rerr;
      tick();
      bus_rvalid = 1'b0; bus_rdata = $urandom; bus_rerr = 1'($urandom);
      if (c == rv_dly || c == T - 1) done = 1'b1;
      c++;
    end
    bus_rerr = 1'b0;

    checks++;
    if ({resp_valid, resp_unknowntype, resp_missaligned, resp_accessfault} !== {3'b100, exp_af} || resp_data !== exp_data) begin
      errors++;
      $display("FAIL %s resp got v/unk/mis/af=%b%b%b%b data=%h want=100%b data=%h",
               tag, resp_valid, resp_unknowntype, resp_missaligned, resp_accessfault, resp_data, exp_af, exp_data);
    end
    tick();
    checks++;
    if ({resp_valid, req_ready, bus_valid} !== 3'b010) begin
      errors++;
      $display("FAIL %s resp_after got v/rdy/bv=%b%b%b want=010", tag, resp_valid, req_ready, bus_valid);
    end
    $display("txn %s addr=%h wr=%0d type=%0d rdly=%0d vdly=%0d -> data=%h af=%0d", tag, addr, wr, typ, rdy_dly, rv_dly, exp_data, exp_af);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_missaligned, resp_unknowntype, resp_accessfault,
         bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb} !== 104'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b rv=%b rd=%h bv=%b ba=%h bw=%b bd=%h bs=%h want all 0",
               req_ready, resp_valid, resp_data, bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release req_ready got=%b want=1", req_ready);
    end
    $display("txn reset done");
  endtask

  task automatic test_directed();
    do_txn(32'h0000_1003, 1'b0, 3'd0, 32'h0, 32'h80FF_0000, 1'b0, 0, 0, "load_byte");
    do_txn(32'h0000_2002, 1'b0, 3'd5, 32'h0, 32'hBEEF_1234, 1'b0, 0, 0, "load_half_u");
    do_txn(32'h0000_2002, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 0, 0, "load_word_mis");
    do_txn(32'h0000_3002, 1'b1, 3'd1, 32'h0000_ABCD, 32'h1234_5678, 1'b0, 0, 0, "store_half");
    do_txn(32'h0000_4000, 1'b0, 3'd3, 32'h0, 32'h0, 1'b0, 0, 0, "unknown_type");
    do_txn(32'h0000_5001, 1'b1, 3'd0, 32'h0000_0055, 32'h0, 1'b0, 0, 1, "store_byte");
    do_txn(32'h0000_6000, 1'b0, 3'd2, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 2, "bus_error");
  endtask

  task automatic test_timeout();
    do_txn(32'h0000_7000, 1'b0, 3'd2, 32'h0, 32'h1111_2222, 1'b0, 0, 1000, "timeout");
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({resp_valid, req_ready, bus_valid} !== 3'b010) begin
        errors++;
        $display("FAIL late_rvalid[%0d] got v/rdy/bv=%b%b%b want=010", i, resp_valid, req_ready, bus_valid);
      end
      tick();
    end
    bus_rvalid = 1'b0;
    do_txn(32'h0000_7004, 1'b0, 3'd4, 32'h0, 32'h0000_00F3, 1'b0, 0, 0, "after_timeout");
    do_txn(32'h0000_7008, 1'b0, 3'd1, 32'h0, 32'h0000_8001, 1'b0, 0, T - 1, "race_rvalid");
  endtask

  task automatic test_bus_stall();
    do_txn(32'h0000_8006, 1'b0, 3'd1, 32'h0, 32'h9876_5432, 1'b0, 10, 0, "stall_load");
    do_txn(32'h0000_800C, 1'b1, 3'd2, 32'h0102_0304, 32'h0, 1'b0, 10, 3, "stall_store");
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_addr = 32'h0000_9000; req_write = 1'b0; req_type = 3'd2;
    tick();
    req_valid = 1'b0; bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_missaligned, resp_unknowntype, resp_accessfault,
         bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb} !== 104'h0) begin
      errors++;
      $display("FAIL reset_in_wait got rdy=%b rv=%b rd=%h bv=%b ba=%h want all 0",
               req_ready, resp_valid, resp_data, bus_valid, bus_addr);
    end
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_rvalid = 1'b0;
    checks++;
    if ({resp_valid, req_ready, bus_valid} !== 3'b010) begin
      errors++;
      $display("FAIL reset_in_wait_idle got v/rdy/bv=%b%b%b want=010", resp_valid, req_ready, bus_valid);
    end
    $display("txn reset_in_wait done");
    do_txn(32'h0000_9002, 1'b0, 3'd1, 32'h0, 32'h8000_0000, 1'b0, 0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          rv;
      a  = $urandom;
      rv = ($urandom_range(0, 7) == 0) ? T + 2 : $urandom_range(0, T - 1);
      do_txn(a, 1'($urandom), 3'($urandom), $urandom, $urandom, ($urandom_range(0, 7) == 0),
             $urandom_range(0, 3), rv, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_bus_stall();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
